// File: rtl/spi_command_decoder.sv
// SPI command decoder: parses opcode/address/value frames from the SPI slave
// byte stream into single-cycle core commands and sources STREAM/TRANSFER reply bytes.
module spi_command_decoder #(
  parameter int         ADDR_BYTES        = 3,
  parameter int         VALUE_BYTES       = 4,
  parameter logic [7:0] OP_WRITE          = 8'h01,
  parameter logic [7:0] OP_READ           = 8'h02,
  parameter logic [7:0] OP_STREAM         = 8'h03,
  parameter logic [7:0] OP_BIND_INTERRUPT = 8'h04,
  parameter logic [7:0] OP_BIND_READ      = 8'h05,
  parameter logic [7:0] OP_BIND_WRITE     = 8'h06,
  parameter logic [7:0] OP_TRANSFER       = 8'h07,
  parameter logic [7:0] OP_REPEAT         = 8'h08
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     spi_rx_valid,
  input  logic [7:0]               spi_rx_byte,
  input  logic                     spi_frame_abort,
  input  logic [8*VALUE_BYTES-1:0] read_value,
  input  logic [8*VALUE_BYTES-1:0] stream_value,
  output logic [7:0]               spi_tx_byte,
  output logic                     cmd_valid,
  output logic [7:0]               cmd_opcode,
  output logic [8*ADDR_BYTES-1:0]  cmd_address,
  output logic [8*VALUE_BYTES-1:0] cmd_value,
  output logic                     cmd_error,
  output logic                     busy
);

  localparam int PB = ADDR_BYTES + VALUE_BYTES;
  localparam int RW = $clog2(PB + 1);
  localparam int PW = (VALUE_BYTES > 1) ? $clog2(VALUE_BYTES) : 1;
  localparam int SW = $clog2(VALUE_BYTES + 1);

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_COLLECT = 1'b1;

  logic                     state;
  logic [RW-1:0]            remaining;
  logic [7:0]               opcode_q;
  logic [8*PB-1:0]          payload;
  logic [8*VALUE_BYTES-1:0] stream_snap;
  logic [SW-1:0]            stream_idx;
  logic [8*VALUE_BYTES-1:0] read_snap;
  logic [PW-1:0]            tx_ptr;

  logic [8*PB-1:0]          payload_next;
  logic [8*VALUE_BYTES-1:0] xfer_src;
  logic [7:0]               xfer_byte;
  logic [7:0]               stream_byte;
  int unsigned              xfer_idx;
  int unsigned              stream_sel;

  assign busy = (state == ST_COLLECT);

  always_comb begin
    payload_next = {payload[8*PB-9:0], spi_rx_byte};
    // Pointer 0 starts a new sequence, so the live value is what gets snapshotted.
    xfer_src     = (tx_ptr == '0) ? read_value : read_snap;
    xfer_idx     = VALUE_BYTES - 1 - 32'(tx_ptr);
    xfer_byte    = xfer_src[8*xfer_idx +: 8];
    stream_sel   = 0;
    stream_byte  = '0;
    if (32'(stream_idx) < VALUE_BYTES) begin
      stream_sel  = VALUE_BYTES - 1 - 32'(stream_idx);
      stream_byte = stream_snap[8*stream_sel +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      opcode_q    <= '0;
      payload     <= '0;
      stream_snap <= '0;
      stream_idx  <= '0;
      read_snap   <= '0;
      tx_ptr      <= '0;
      spi_tx_byte <= '0;
      cmd_valid   <= 1'b0;
      cmd_opcode  <= '0;
      cmd_address <= '0;
      cmd_value   <= '0;
      cmd_error   <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      cmd_error <= 1'b0;
      if (spi_frame_abort) begin
        state     <= ST_IDLE;
        remaining <= '0;
        payload   <= '0;
        tx_ptr    <= '0;
      end else if (spi_rx_valid) begin
        if (state == ST_IDLE) begin
          case (spi_rx_byte)
            OP_WRITE: begin
              state     <= ST_COLLECT;
              opcode_q  <= spi_rx_byte;
              remaining <= RW'(PB);
            end
            OP_READ, OP_BIND_INTERRUPT, OP_BIND_READ, OP_BIND_WRITE: begin
              state     <= ST_COLLECT;
              opcode_q  <= spi_rx_byte;
              remaining <= RW'(ADDR_BYTES);
            end
            OP_STREAM: begin
              state       <= ST_COLLECT;
              opcode_q    <= spi_rx_byte;
              remaining   <= RW'(VALUE_BYTES);
              stream_snap <= stream_value;
              spi_tx_byte <= stream_value[8*VALUE_BYTES-1 -: 8];
              stream_idx  <= SW'(1);
            end
            OP_TRANSFER: begin
              if (tx_ptr == '0) read_snap <= read_value;
              spi_tx_byte <= xfer_byte;
              tx_ptr      <= (tx_ptr == PW'(VALUE_BYTES - 1)) ? '0 : tx_ptr + PW'(1);
            end
            OP_REPEAT: tx_ptr <= '0;
            default:   cmd_error <= 1'b1;
          endcase
        end else begin
          payload   <= payload_next;
          remaining <= remaining - RW'(1);
          if (opcode_q == OP_STREAM) begin
            spi_tx_byte <= stream_byte;
            if (32'(stream_idx) < VALUE_BYTES) stream_idx <= stream_idx + SW'(1);
          end
          if (remaining == RW'(1)) begin
            state      <= ST_IDLE;
            cmd_valid  <= 1'b1;
            cmd_opcode <= opcode_q;
            if (opcode_q == OP_WRITE) begin
              cmd_address <= payload_next[8*PB-1 -: 8*ADDR_BYTES];
              cmd_value   <= payload_next[8*VALUE_BYTES-1:0];
            end else if (opcode_q == OP_STREAM) begin
              cmd_address <= '0;
              cmd_value   <= payload_next[8*VALUE_BYTES-1:0];
            end else begin
              cmd_address <= payload_next[8*ADDR_BYTES-1:0];
              cmd_value   <= '0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_command_decoder.sv
// Scoreboard bench for spi_command_decoder: byte-level reference model feeds an
// expected-command queue that an independent monitor drains on cmd_valid/cmd_error.
module tb_spi_command_decoder;

  localparam int A = 3;
  localparam int V = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             spi_rx_valid = 1'b0;
  logic [7:0]       spi_rx_byte = '0;
  logic             spi_frame_abort = 1'b0;
  logic [8*V-1:0]   read_value = '0;
  logic [8*V-1:0]   stream_value = '0;
  logic [7:0]       spi_tx_byte;
  logic             cmd_valid;
  logic [7:0]       cmd_opcode;
  logic [8*A-1:0]   cmd_address;
  logic [8*V-1:0]   cmd_value;
  logic             cmd_error;
  logic             busy;

  spi_command_decoder #(.ADDR_BYTES(A), .VALUE_BYTES(V)) dut (
    .clk(clk), .rst(rst), .spi_rx_valid(spi_rx_valid), .spi_rx_byte(spi_rx_byte),
    .spi_frame_abort(spi_frame_abort), .read_value(read_value), .stream_value(stream_value),
    .spi_tx_byte(spi_tx_byte), .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode),
    .cmd_address(cmd_address), .cmd_value(cmd_value), .cmd_error(cmd_error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [63:0] addr;
    logic [63:0] val;
  } exp_t;

  exp_t       expq[$];
  int         exp_err = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  // Reference model state: one frame at a time, fields kept as byte lists.
  bit         m_collect = 0;
  int         m_len = 0;
  logic [7:0] m_op = '0;
  logic [7:0] m_tx = '0;
  logic [7:0] pay[$];
  logic [7:0] ss[V];
  logic [7:0] rs[V];
  int         m_ptr = 0;
  int         s_idx = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_collect = 0; m_len = 0; m_op = '0; m_tx = '0; m_ptr = 0; s_idx = 0;
    pay.delete();
  endtask

  task automatic model_abort();
    m_collect = 0; m_ptr = 0;
    pay.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input logic [8*V-1:0] rv, input logic [8*V-1:0] sv);
    logic [63:0] addr;
    logic [63:0] val;
    if (!m_collect) begin
      case (b)
        8'h01: begin m_op = b; m_len = A + V; m_collect = 1; end
        8'h02, 8'h04, 8'h05, 8'h06: begin m_op = b; m_len = A; m_collect = 1; end
        8'h03: begin
          m_op = b; m_len = V; m_collect = 1;
          for (int i = 0; i < V; i++) ss[i] = 8'(sv >> (8 * (V - 1 - i)));
          m_tx = ss[0];
          s_idx = 1;
        end
        8'h07: begin
          if (m_ptr == 0)
            for (int i = 0; i < V; i++) rs[i] = 8'(rv >> (8 * (V - 1 - i)));
          m_tx = rs[m_ptr];
          m_ptr = (m_ptr + 1) % V;
        end
        8'h08: m_ptr = 0;
        default: exp_err++;
      endcase
    end else begin
      pay.push_back(b);
      if (m_op == 8'h03) begin
        m_tx = (s_idx < V) ? ss[s_idx] : 8'h00;
        s_idx++;
      end
      if (pay.size() == m_len) begin
        addr = 0; val = 0;
        for (int i = 0; i < pay.size(); i++) begin
          if (m_op == 8'h01) begin
            if (i < A) addr = addr * 256 + 64'(pay[i]);
            else       val  = val * 256 + 64'(pay[i]);
          end else if (m_op == 8'h03) val = val * 256 + 64'(pay[i]);
          else addr = addr * 256 + 64'(pay[i]);
        end
        expq.push_back('{m_op, addr, val});
        m_collect = 0;
        pay.delete();
      end
    end
  endtask

  // Driver: inputs change 1 time unit after the rising edge.
  task automatic send(input logic [7:0] b);
    spi_rx_byte = b;
    spi_rx_valid = 1'b1;
    @(posedge clk);
    #1;
    spi_rx_valid = 1'b0;
    model_byte(b, read_value, stream_value);
    chk("spi_tx_byte", 64'(spi_tx_byte), 64'(m_tx));
    chk("busy", 64'(busy), 64'(m_collect));
  endtask

  task automatic abort_frame(input bit with_byte);
    spi_frame_abort = 1'b1;
    spi_rx_valid = with_byte;
    spi_rx_byte = 8'($urandom);
    @(posedge clk);
    #1;
    spi_frame_abort = 1'b0;
    spi_rx_valid = 1'b0;
    model_abort();
    chk("busy_after_abort", 64'(busy), 64'(0));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tx"}, 64'(spi_tx_byte), 64'(0));
    chk({tag, "_valid"}, 64'(cmd_valid), 64'(0));
    chk({tag, "_opcode"}, 64'(cmd_opcode), 64'(0));
    chk({tag, "_address"}, 64'(cmd_address), 64'(0));
    chk({tag, "_value"}, 64'(cmd_value), 64'(0));
    chk({tag, "_error"}, 64'(cmd_error), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  // Monitor: consumes expectations whenever the DUT presents a strobe.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid) begin
        chk("cmd_valid_expected", 64'(expq.size() != 0), 64'(1));
        if (expq.size() != 0) begin
          mon_e = expq.pop_front();
          chk("cmd_opcode", 64'(cmd_opcode), 64'(mon_e.op));
          chk("cmd_address", 64'(cmd_address), 64'(mon_e.addr[8*A-1:0]));
          chk("cmd_value", 64'(cmd_value), 64'(mon_e.val[8*V-1:0]));
        end
      end
      if (cmd_error) begin
        chk("cmd_error_expected", 64'(exp_err > 0), 64'(1));
        if (exp_err > 0) exp_err--;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] ops[9];
  int r;

  initial begin
    ops = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hFF};
    #2;
    check_all_zero("reset");
    #10;
    rst = 1'b0;
    model_reset();
    idle(1);

    // WRITE
    foreach (ops[i]) ; // keep ops referenced before random phase
    send(8'h01); send(8'hAA); send(8'hBB); send(8'hCC);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    idle(2);

    // READ then BIND_READ back-to-back
    send(8'h02); send(8'h00); send(8'h00); send(8'h10);
    send(8'h05); send(8'h00); send(8'h00); send(8'h20);
    idle(1);

    // STREAM
    stream_value = 32'hDEADBEEF;
    send(8'h03); chk("stream_first_tx", 64'(spi_tx_byte), 64'hDE);
    stream_value = 32'h0;
    send(8'h5A); send(8'hA5); send(8'h3C); send(8'hC3);
    idle(1);

    // TRANSFER with mid-sequence read_value change
    read_value = 32'h12345678;
    send(8'h07); send(8'h07); send(8'h07);
    read_value = 32'h0;
    send(8'h07); chk("transfer_last_tx", 64'(spi_tx_byte), 64'h78);
    send(8'h08); send(8'h07); chk("transfer_new_snap", 64'(spi_tx_byte), 64'h00);
    idle(1);

    // Abort mid-WRITE, then READ; unknown opcode
    send(8'h01); send(8'hAA); send(8'hBB);
    abort_frame(1'b1);
    send(8'h02); send(8'h00); send(8'h00); send(8'h01);
    send(8'hFF);
    idle(2);

    // Async reset between clock edges mid-WRITE
    send(8'h01); send(8'hAA); send(8'hBB);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    #2;
    rst = 1'b0;
    model_reset();
    idle(1);
    send(8'h02); send(8'h00); send(8'h00); send(8'h42);
    idle(2);

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4) abort_frame(1'($urandom));
      else if (r < 10) idle($urandom_range(1, 3));
      else if (r < 16) begin
        read_value = 32'($urandom);
        stream_value = 32'($urandom);
      end else if (!m_collect) begin
        if ($urandom_range(0, 9) == 0) send(8'($urandom));
        else send(ops[$urandom_range(0, 7)]);
      end else send(8'($urandom));
    end
    idle(3);

    chk("expected_cmds_drained", 64'(expq.size()), 64'(0));
    chk("expected_errors_drained", 64'(exp_err), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
